fp_div_prog: RTL

//  Multi-channel, runtime-programmable fractional clock divider for PSG/audio clock generation.

---
 rtl/fp_div_pkg.sv | 24 ++
 rtl/fp_div_chan.sv | 142 ++++++++++++++
 rtl/fp_div_prog.sv | 73 +++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared types, constants and the period helper for the fractional clock divider.
//  period_int_t / period_frac_t : integer and fractional period at the default widths
//  MIN_INT                      : smallest legal integer period
//  calc_period(in, out, fbits)  : fixed-point ratio in/out with fbits fractional bits,
//                                 returned as {int, frac} in 64 bits
package fp_div_pkg;

    localparam int unsigned INT_W   = 13;
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned MIN_INT = 2;

    typedef logic [INT_W-1:0]  period_int_t;
    typedef logic [FRAC_W-1:0] period_frac_t;

    // {int, frac} = in_hz * 2^frac_bits / out_hz, truncated
    function automatic logic [63:0] calc_period(
        input logic [63:0] in_hz,
        input logic [63:0] out_hz,
        input int unsigned frac_bits
    );
        return (in_hz << frac_bits) / out_hz;
    endfunction

endpackage

// File: rtl/fp_div_chan.sv
// One fractional divider channel: integer counter, fractional accumulator,
// shadow/active period registers and registered strobe / clock outputs.
//  clk_in   in   system clock
//  reset    in   synchronous active-high reset
//  ena      in   run enable; when low the phase is held at zero
//  sync     in   phase restart, applies any pending shadow
//  wr_hit   in   write addressed to this channel this cycle
//  wr_int   in   new integer period (already clamped to the minimum)
//  wr_frac  in   new fractional period
//  pending  out  a written period waits for the next boundary
//  strobe   out  one-cycle pulse per output period
//  clk_out  out  divided clock, high for floor(INT/2) cycles per period
module fp_div_chan
    import fp_div_pkg::*;
#(
    parameter int unsigned          INT_BITS  = 13,
    parameter int unsigned          FRAC_BITS = 16,
    parameter logic [INT_BITS-1:0]  DEF_INT   = INT_BITS'(27),
    parameter logic [FRAC_BITS-1:0] DEF_FRAC  = '0
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 ena,
    input  logic                 sync,
    input  logic                 wr_hit,
    input  logic [INT_BITS-1:0]  wr_int,
    input  logic [FRAC_BITS-1:0] wr_frac,
    output logic                 pending,
    output logic                 strobe,
    output logic                 clk_out
);

    logic [INT_BITS-1:0]  m_q, nxt_m;
    logic [FRAC_BITS:0]   n_q, nxt_n;
    logic [INT_BITS-1:0]  act_int_q, nxt_act_int;
    logic [FRAC_BITS-1:0] act_frac_q, nxt_act_frac;
    logic [INT_BITS-1:0]  sh_int_q, nxt_sh_int;
    logic [FRAC_BITS-1:0] sh_frac_q, nxt_sh_frac;
    logic                 pend_q, nxt_pend;
    logic                 strobe_q, nxt_strobe;
    logic                 clk_q, nxt_clk;

    logic [INT_BITS-1:0]  term_cnt;
    logic [INT_BITS-1:0]  half_cnt;
    logic                 terminal;
    logic                 half_hit;

    // A set carry stretches the current period by one cycle
    assign term_cnt = act_int_q - INT_BITS'(1) + INT_BITS'(n_q[FRAC_BITS]);
    assign half_cnt = (act_int_q >> 1) - INT_BITS'(1);
    assign terminal = (m_q == term_cnt);
    assign half_hit = (m_q == half_cnt);

    // Next-state: sync beats everything, then boundary apply, then counting
    always_comb begin
        nxt_m        = m_q;
        nxt_n        = n_q;
        nxt_act_int  = act_int_q;
        nxt_act_frac = act_frac_q;
        nxt_sh_int   = sh_int_q;
        nxt_sh_frac  = sh_frac_q;
        nxt_pend     = pend_q;
        nxt_strobe   = 1'b0;
        nxt_clk      = clk_q;

        if (sync) begin
            // A same-cycle write behaves as if it landed just before sync
            if (wr_hit) begin
                nxt_act_int  = wr_int;
                nxt_act_frac = wr_frac;
                nxt_sh_int   = wr_int;
                nxt_sh_frac  = wr_frac;
            end else if (pend_q) begin
                nxt_act_int  = sh_int_q;
                nxt_act_frac = sh_frac_q;
            end
            nxt_pend = 1'b0;
            nxt_m    = '0;
            nxt_n    = '0;
            nxt_clk  = 1'b0;
        end else begin
            // Old shadow moves to active; a write in the same cycle re-arms pending
            if (pend_q && (!ena || terminal)) begin
                nxt_act_int  = sh_int_q;
                nxt_act_frac = sh_frac_q;
                nxt_pend     = 1'b0;
            end
            if (wr_hit) begin
                nxt_sh_int  = wr_int;
                nxt_sh_frac = wr_frac;
                nxt_pend    = 1'b1;
            end

            if (!ena) begin
                nxt_m   = '0;
                nxt_n   = '0;
                nxt_clk = 1'b0;
            end else if (terminal) begin
                // Dropping the MSB clears the carry just consumed
                nxt_m      = '0;
                nxt_n      = {1'b0, n_q[FRAC_BITS-1:0]} + {1'b0, nxt_act_frac};
                nxt_strobe = 1'b1;
                nxt_clk    = 1'b1;
            end else begin
                nxt_m = m_q + INT_BITS'(1);
                if (half_hit) begin
                    nxt_clk = 1'b0;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            m_q        <= '0;
            n_q        <= '0;
            act_int_q  <= DEF_INT;
            act_frac_q <= DEF_FRAC;
            sh_int_q   <= DEF_INT;
            sh_frac_q  <= DEF_FRAC;
            pend_q     <= 1'b0;
            strobe_q   <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            m_q        <= nxt_m;
            n_q        <= nxt_n;
            act_int_q  <= nxt_act_int;
            act_frac_q <= nxt_act_frac;
            sh_int_q   <= nxt_sh_int;
            sh_frac_q  <= nxt_sh_frac;
            pend_q     <= nxt_pend;
            strobe_q   <= nxt_strobe;
            clk_q      <= nxt_clk;
        end
    end

    assign pending = pend_q;
    assign strobe  = strobe_q;
    assign clk_out = clk_q;

endmodule

// File: rtl/fp_div_prog.sv
// Multi-channel runtime-programmable fractional clock divider.
// Each channel divides clk_in by INT + FRAC/2^FRAC_BITS; new periods are written
// into a shadow and take effect at that channel's next period boundary.
//  clk_in       in   system clock
//  reset        in   synchronous active-high reset
//  wr_ena       in   period write strobe
//  wr_chan      in   target channel (values >= CHANNELS are ignored)
//  wr_int       in   new integer period (values below MIN_INT clamp to MIN_INT)
//  wr_frac      in   new fractional period
//  sync         in   restart the phase of all channels together
//  ena          in   per-channel run enable
//  pending_out  out  per-channel written period still waiting for its boundary
//  strobe_out   out  per-channel one-cycle pulse per output period
//  clk_out      out  per-channel divided clock
module fp_div_prog
    import fp_div_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned INT_BITS     = 13,
    parameter int unsigned FRAC_BITS    = 16,
    parameter logic [63:0] INPUT_CLK_HZ = 64'd100000000,
    parameter logic [63:0] DEFAULT_HZ   = 64'd3579545
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic                                  wr_ena,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
    input  logic [INT_BITS-1:0]                   wr_int,
    input  logic [FRAC_BITS-1:0]                  wr_frac,
    input  logic                                  sync,
    input  logic [CHANNELS-1:0]                   ena,
    output logic [CHANNELS-1:0]                   pending_out,
    output logic [CHANNELS-1:0]                   strobe_out,
    output logic [CHANNELS-1:0]                   clk_out
);

    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Reset-default period in 64-bit fixed point
    localparam logic [63:0]          DEF_PERIOD = calc_period(INPUT_CLK_HZ, DEFAULT_HZ, FRAC_BITS);
    localparam logic [INT_BITS-1:0]  DEF_INT    = INT_BITS'(DEF_PERIOD >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC   = FRAC_BITS'(DEF_PERIOD);

    logic [INT_BITS-1:0] wr_int_clamped;

    // Periods below two cycles cannot hold a high and a low phase
    assign wr_int_clamped = (wr_int < INT_BITS'(MIN_INT)) ? INT_BITS'(MIN_INT) : wr_int;

    // Only existing channels decode a hit, so out-of-range addresses drop out
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic hit;
        assign hit = wr_ena && (wr_chan == CHAN_W'(c));

        fp_div_chan #(
            .INT_BITS  (INT_BITS),
            .FRAC_BITS (FRAC_BITS),
            .DEF_INT   (DEF_INT),
            .DEF_FRAC  (DEF_FRAC)
        ) u_chan (
            .clk_in  (clk_in),
            .reset   (reset),
            .ena     (ena[c]),
            .sync    (sync),
            .wr_hit  (hit),
            .wr_int  (wr_int_clamped),
            .wr_frac (wr_frac),
            .pending (pending_out[c]),
            .strobe  (strobe_out[c]),
            .clk_out (clk_out[c])
        );
    end

endmodule
